// File: rtl/lsu.sv
// Load/store unit: turns one core load/store into a single req/gnt/rvalid bus
// access and returns the sign- or zero-extended load result for writeback.
module lsu #(
    parameter int XLEN = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic              lsu_read,
    input  logic              lsu_write,
    input  logic [2:0]        lsu_funct3,
    input  logic [XLEN-1:0]   lsu_addr,
    input  logic [XLEN-1:0]   lsu_wdata,
    output logic [XLEN-1:0]   lsu_rdata,
    output logic              lsu_done,
    output logic              lsu_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t      state_r, state_s;
    logic        is_read_r, is_read_s;
    logic [2:0]  funct3_r, funct3_s;
    logic [1:0]  addr_lo_r, addr_lo_s;
    logic [31:0] rdata_r, rdata_s;
    logic        done_r, done_s;
    logic        err_r, err_s;
    logic        req_r, req_s;
    logic        we_r, we_s;
    logic [31:0] addr_r, addr_s;
    logic [3:0]  wstrb_r, wstrb_s;
    logic [31:0] wdata_r, wdata_s;

    // Illegal funct3 for the direction, or a half/word not naturally aligned.
    function automatic logic access_bad(input logic rd, input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            3'b000:         access_bad = 1'b0;
            3'b001:         access_bad = lo[0];
            3'b010:         access_bad = |lo;
            3'b100, 3'b101: access_bad = !rd || (f3[0] && lo[0]);
            default:        access_bad = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   store_strb = 4'b0001 << lo;
            2'b01:   store_strb = lo[1] ? 4'b1100 : 4'b0011;
            default: store_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   store_data = {4{wd[7:0]}};
            2'b01:   store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_data(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  load_data = {{24{b[7]}}, b};
            3'b001:  load_data = {{16{h[15]}}, h};
            3'b100:  load_data = {24'd0, b};
            3'b101:  load_data = {16'd0, h};
            default: load_data = rd;
        endcase
    endfunction

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            is_read_r <= 1'b0;
            funct3_r  <= 3'd0;
            addr_lo_r <= 2'd0;
            rdata_r   <= 32'd0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            req_r     <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= 32'd0;
            wstrb_r   <= 4'd0;
            wdata_r   <= 32'd0;
        end else begin
            state_r   <= state_s;
            is_read_r <= is_read_s;
            funct3_r  <= funct3_s;
            addr_lo_r <= addr_lo_s;
            rdata_r   <= rdata_s;
            done_r    <= done_s;
            err_r     <= err_s;
            req_r     <= req_s;
            we_r      <= we_s;
            addr_r    <= addr_s;
            wstrb_r   <= wstrb_s;
            wdata_r   <= wdata_s;
        end
    end

    // Next-state and next-output logic; bus fields hold until the grant.
    always_comb begin
        state_s   = state_r;
        is_read_s = is_read_r;
        funct3_s  = funct3_r;
        addr_lo_s = addr_lo_r;
        rdata_s   = rdata_r;
        done_s    = 1'b0;
        err_s     = 1'b0;
        req_s     = req_r;
        we_s      = we_r;
        addr_s    = addr_r;
        wstrb_s   = wstrb_r;
        wdata_s   = wdata_r;
        case (state_r)
            IDLE: begin
                if (lsu_valid && (lsu_read || lsu_write)) begin
                    is_read_s = lsu_read;
                    funct3_s  = lsu_funct3;
                    addr_lo_s = lsu_addr[1:0];
                    if (access_bad(lsu_read, lsu_funct3, lsu_addr[1:0])) begin
                        state_s = DONE;
                        done_s  = 1'b1;
                        err_s   = 1'b1;
                    end else begin
                        state_s = REQ;
                        req_s   = 1'b1;
                        we_s    = !lsu_read;
                        addr_s  = {lsu_addr[31:2], 2'b00};
                        wstrb_s = lsu_read ? 4'd0 : store_strb(lsu_funct3, lsu_addr[1:0]);
                        wdata_s = lsu_read ? 32'd0 : store_data(lsu_funct3, lsu_wdata);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    req_s = 1'b0;
                    if (is_read_r) begin
                        state_s = RESP;
                    end else begin
                        state_s = DONE;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = REQ;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    rdata_s = load_data(funct3_r, addr_lo_r, mem_rdata);
                    state_s = DONE;
                    done_s  = 1'b1;
                end else begin
                    state_s = RESP;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign lsu_ready = (state_r == IDLE) && !reset;
    assign lsu_rdata = rdata_r;
    assign lsu_done  = done_r;
    assign lsu_err   = err_r;
    assign mem_req   = req_r;
    assign mem_we    = we_r;
    assign mem_addr  = addr_r;
    assign mem_wstrb = wstrb_r;
    assign mem_wdata = wdata_r;

endmodule

// File: tb/tb_lsu.sv
// Table-driven bench for lsu with a queued scoreboard and a scripted memory responder.
module tb_lsu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        lsu_valid = 1'b0, lsu_read = 1'b0, lsu_write = 1'b0;
    logic [2:0]  lsu_funct3 = 3'd0;
    logic [31:0] lsu_addr = 32'd0, lsu_wdata = 32'd0;
    logic        lsu_ready, lsu_done, lsu_err;
    logic [31:0] lsu_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int          n_cmp = 0;
    int          n_fail = 0;

    // Responder configuration, written only by the stimulus process.
    int          gnt_delay_cfg = 0;
    logic [31:0] rdata_cfg = 32'd0;
    bit          rv_block = 1'b0;
    bit          stray_rv = 1'b0;
    // Responder state, written only by the responder.
    int          req_cnt = 0;
    bit          rv_pend = 1'b0;

    lsu dut (
        .clock(clock), .reset(reset),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_read(lsu_read), .lsu_write(lsu_write),
        .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_rdata(lsu_rdata), .lsu_done(lsu_done), .lsu_err(lsu_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Memory model: grant after gnt_delay_cfg stall cycles, read data one cycle after grant.
    always @(negedge clock) begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (rv_pend) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata_cfg;
            rv_pend    = 1'b0;
        end else if (stray_rv) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hFFFF_FFFF;
        end
        if (mem_req && !reset) begin
            if (req_cnt >= gnt_delay_cfg) begin
                mem_gnt = 1'b1;
                req_cnt = 0;
                if (!mem_we && !rv_block) rv_pend = 1'b1;
            end else begin
                req_cnt++;
            end
        end else begin
            req_cnt = 0;
        end
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gd;
        logic        err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        int          lat;
        int          req_cycles;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    vec_t tbl[18];
    exp_t sb[$];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int gd, input logic err,
                                input logic [31:0] exp_rdata, input logic [31:0] exp_addr,
                                input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.gd = gd; v.err = err; v.exp_rdata = exp_rdata; v.exp_addr = exp_addr;
        v.exp_strb = exp_strb; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        int   cyc;
        int   reqc;
        bit   seen;
        gnt_delay_cfg = v.gd;
        rdata_cfg     = v.rdata;
        chk($sformatf("v%0d_ready_before", idx), {31'd0, lsu_ready}, 32'd1);
        lsu_valid  = 1'b1;
        lsu_read   = v.rd;
        lsu_write  = v.wr;
        lsu_funct3 = v.f3;
        lsu_addr   = v.addr;
        lsu_wdata  = v.wdata;
        e.err        = v.err;
        e.rdata      = v.exp_rdata;
        e.lat        = v.err ? 1 : (v.rd ? v.gd + 3 : v.gd + 2);
        e.req_cycles = v.err ? 0 : v.gd + 1;
        sb.push_back(e);
        cyc = 0; reqc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            lsu_valid = 1'b0; lsu_read = 1'b0; lsu_write = 1'b0;
            if (mem_req) begin
                reqc++;
                chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.exp_addr);
                chk($sformatf("v%0d_mem_we", idx), {31'd0, mem_we}, {31'd0, !v.rd});
                chk($sformatf("v%0d_mem_wstrb", idx), {28'd0, mem_wstrb}, {28'd0, v.exp_strb});
                chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.exp_wdata);
            end
            if (lsu_done) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL v%0d_scoreboard: done with no expected entry", idx);
                end else begin
                    got = sb.pop_front();
                    chk($sformatf("v%0d_latency", idx), cyc, got.lat);
                    chk($sformatf("v%0d_err", idx), {31'd0, lsu_err}, {31'd0, got.err});
                    chk($sformatf("v%0d_rdata", idx), lsu_rdata, got.rdata);
                    chk($sformatf("v%0d_req_cycles", idx), reqc, got.req_cycles);
                end
            end
        end
        if (!seen) begin
            n_cmp++; n_fail++;
            $display("FAIL v%0d_done_timeout: no lsu_done within %0d cycles", idx, cyc);
            void'(sb.pop_front());
        end
        tick();
        chk($sformatf("v%0d_done_pulse", idx), {31'd0, lsu_done}, 32'd0);
        chk($sformatf("v%0d_ready_after", idx), {31'd0, lsu_ready}, 32'd1);
    endtask

    initial begin
        int rises[$];
        int dones[$];
        logic prev_req;

        tbl[0]  = mk(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 32'h100, 4'h0, 32'h0);
        tbl[1]  = mk(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, 1'b0, 32'hFFFFFF80, 32'h100, 4'h0, 32'h0);
        tbl[2]  = mk(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1, 1'b0, 32'h00000080, 32'h100, 4'h0, 32'h0);
        tbl[3]  = mk(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80112233, 0, 1'b0, 32'h00008011, 32'h100, 4'h0, 32'h0);
        tbl[4]  = mk(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80112233, 2, 1'b0, 32'hFFFF8011, 32'h100, 4'h0, 32'h0);
        tbl[5]  = mk(1'b0, 1'b1, 3'b001, 32'h206, 32'h1234ABCD, 32'h0, 3, 1'b0, 32'hFFFF8011, 32'h204, 4'hC, 32'hABCDABCD);
        tbl[6]  = mk(1'b0, 1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h0, 0, 1'b0, 32'hFFFF8011, 32'h300, 4'h2, 32'hA5A5A5A5);
        tbl[7]  = mk(1'b0, 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 1, 1'b0, 32'hFFFF8011, 32'h400, 4'hF, 32'hCAFEF00D);
        tbl[8]  = mk(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h11111111, 0, 1'b1, 32'hFFFF8011, 32'h0, 4'h0, 32'h0);
        tbl[9]  = mk(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h11111111, 0, 1'b1, 32'hFFFF8011, 32'h0, 4'h0, 32'h0);
        tbl[10] = mk(1'b0, 1'b1, 3'b010, 32'h203, 32'h55555555, 32'h0, 0, 1'b1, 32'hFFFF8011, 32'h0, 4'h0, 32'h0);
        tbl[11] = mk(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h11111111, 0, 1'b1, 32'hFFFF8011, 32'h0, 4'h0, 32'h0);
        tbl[12] = mk(1'b0, 1'b1, 3'b100, 32'h100, 32'h55555555, 32'h0, 0, 1'b1, 32'hFFFF8011, 32'h0, 4'h0, 32'h0);
        tbl[13] = mk(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0, 1'b0, 32'h0000007F, 32'h100, 4'h0, 32'h0);
        tbl[14] = mk(1'b1, 1'b1, 3'b010, 32'h500, 32'hFFFFFFFF, 32'h11223344, 0, 1'b0, 32'h11223344, 32'h500, 4'h0, 32'h0);
        tbl[15] = mk(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'hFFFF8000, 1, 1'b0, 32'h00008000, 32'h100, 4'h0, 32'h0);
        tbl[16] = mk(1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 32'h000000FF, 0, 1'b0, 32'hFFFFFFFF, 32'h100, 4'h0, 32'h0);
        tbl[17] = mk(1'b0, 1'b1, 3'b000, 32'h303, 32'h12345678, 32'h0, 2, 1'b0, 32'hFFFFFFFF, 32'h300, 4'h8, 32'h78787878);

        tick(); tick();
        chk("ready_in_reset", {31'd0, lsu_ready}, 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_ready", {31'd0, lsu_ready}, 32'd1);
        chk("rst_done", {31'd0, lsu_done}, 32'd0);
        chk("rst_err", {31'd0, lsu_err}, 32'd0);
        chk("rst_rdata", lsu_rdata, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);

        // Valid with neither read nor write must be ignored.
        lsu_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nop_mem_req", {31'd0, mem_req}, 32'd0);
            chk("nop_done", {31'd0, lsu_done}, 32'd0);
            chk("nop_ready", {31'd0, lsu_ready}, 32'd1);
        end
        lsu_valid = 1'b0;

        for (int i = 0; i < 18; i++) run_vec(tbl[i], i);

        // Reset while waiting in RESP, followed by a stray rvalid.
        gnt_delay_cfg = 0;
        rv_block = 1'b1;
        lsu_valid = 1'b1; lsu_read = 1'b1; lsu_funct3 = 3'b010; lsu_addr = 32'h700;
        tick();
        lsu_valid = 1'b0; lsu_read = 1'b0;
        chk("rr_req_issued", {31'd0, mem_req}, 32'd1);
        tick();
        chk("rr_in_resp_ready", {31'd0, lsu_ready}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stray_rv = 1'b1;
        chk("rr_req_dropped", {31'd0, mem_req}, 32'd0);
        tick();
        stray_rv = 1'b0;
        rv_block = 1'b0;
        chk("rr_ready", {31'd0, lsu_ready}, 32'd1);
        chk("rr_done", {31'd0, lsu_done}, 32'd0);
        chk("rr_rdata", lsu_rdata, 32'd0);
        chk("rr_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("rr_done_later", {31'd0, lsu_done}, 32'd0);

        // lsu_valid held across a load: one transaction per done.
        gnt_delay_cfg = 0;
        rdata_cfg = 32'hA5A50001;
        lsu_valid = 1'b1; lsu_read = 1'b1; lsu_funct3 = 3'b010; lsu_addr = 32'h600;
        prev_req = mem_req;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (mem_req && !prev_req) rises.push_back(c);
            if (lsu_done) dones.push_back(c);
            prev_req = mem_req;
            if (c == 3) chk("hold_ready_in_done", {31'd0, lsu_ready}, 32'd0);
            if (c == 7) lsu_valid = 1'b0;
        end
        lsu_read = 1'b0;
        chk("hold_rise_count", rises.size(), 32'd2);
        chk("hold_done_count", dones.size(), 32'd2);
        if (rises.size() == 2 && dones.size() == 2) begin
            chk("hold_rise0", rises[0], 32'd1);
            chk("hold_done0", dones[0], 32'd3);
            chk("hold_rise1", rises[1], 32'd5);
            chk("hold_done1", dones[1], 32'd7);
        end
        chk("hold_rdata", lsu_rdata, 32'hA5A50001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
